// File: rtl/counter_monitor_pkg.sv
// -----------------------------------------------------------------------------
// counter_monitor_pkg
// Shared types and helpers for the counter monitor.
//   mon_state_e : monitor FSM states
//   CNT_W       : width of the recovered counter value
//   decode_cnt  : recovers the raw 3-bit count from the 4-bit counter result.
//                 The down range (result[3]=1) is the bitwise inverse of the
//                 up range, so the low bits are inverted back.
// -----------------------------------------------------------------------------
package counter_monitor_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } mon_state_e;

  function automatic logic [CNT_W-1:0] decode_cnt(input logic [3:0] res);
    return res[3] ? ~res[2:0] : res[2:0];
  endfunction

endpackage

// File: rtl/counter_monitor_if.sv
// -----------------------------------------------------------------------------
// counter_monitor_if
// Bundles the counter result bus and the monitor status outputs.
//   clear   : synchronous clear request          (master -> slave)
//   result  : 4-bit counter result               (master -> slave)
//   locked  : monitor is locked                  (slave -> master)
//   err     : one-cycle continuity error pulse   (slave -> master)
//   mode    : last sampled result[3]             (slave -> master)
//   err_cnt : saturating error count             (slave -> master)
//   sw_cnt  : saturating mode-switch count       (slave -> master)
// -----------------------------------------------------------------------------
interface counter_monitor_if #(
  parameter int ERR_W = 8,
  parameter int SW_W  = 8
);

  logic             clear;
  logic [3:0]       result;
  logic             locked;
  logic             err;
  logic             mode;
  logic [ERR_W-1:0] err_cnt;
  logic [SW_W-1:0]  sw_cnt;

  modport master (
    output clear, result,
    input  locked, err, mode, err_cnt, sw_cnt
  );

  modport slave (
    input  clear, result,
    output locked, err, mode, err_cnt, sw_cnt
  );

endinterface

// File: rtl/counter_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst_n : asynchronous reset, active low
//   inc   : count up by one this cycle
//   clr   : synchronous clear to zero (wins over inc)
//   q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // Hold at all-ones once reached so the count never wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_q <= q_q + W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_monitor.sv
// -----------------------------------------------------------------------------
// counter_monitor
// Watches the result bus of an up/down counter, recovers the raw count and
// mode, and checks that the count advances by one (mod 8) every clock.
//   clk    : system clock
//   rst_n  : asynchronous reset, active low
//   bus    : counter_monitor_if slave (clear/result in, status out)
// Status reported: locked, a one-cycle err pulse on a continuity break while
// locked, the current mode, and saturating error / mode-switch counts.
// -----------------------------------------------------------------------------
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int SW_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  counter_monitor_if.slave  bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_VAL = GW'(LOCK_CNT);

  mon_state_e       state_q;
  logic [CNT_W-1:0] prev_cnt_q;
  logic             mode_q;
  logic [GW-1:0]    good_cnt_q;
  logic [GW-1:0]    good_cnt_d;
  logic             locked_q;
  logic             err_q;

  logic [CNT_W-1:0] d_cnt;
  logic             d_mode;
  logic             good;
  logic             err_inc;
  logic             sw_inc;

  // Decode the incoming sample and classify the transition. The mode bit is
  // not part of the continuity check: the counter steps its count on the same
  // edge the mode flips. mode_q doubles as the previous-mode register since
  // both load the sampled result[3] on every edge.
  always_comb begin
    d_cnt      = decode_cnt(bus.result);
    d_mode     = bus.result[3];
    good       = (d_cnt == prev_cnt_q + CNT_W'(1));
    good_cnt_d = good_cnt_q + GW'(1);
    err_inc    = !bus.clear && (state_q == LOCKED) && !good;
    sw_inc     = !bus.clear && (state_q == LOCKED) && good && (d_mode != mode_q);
  end

  // Monitor FSM with registered status outputs. The sample history keeps
  // loading even during clear so the first sample after clear is compared
  // against real data once acquisition restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_cnt_q <= '0;
      mode_q     <= 1'b0;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_cnt_q <= d_cnt;
      mode_q     <= d_mode;
      err_q      <= 1'b0;
      if (bus.clear) begin
        state_q    <= IDLE;
        good_cnt_q <= '0;
        locked_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= ACQ;
            good_cnt_q <= '0;
          end
          ACQ: begin
            if (good) begin
              if (good_cnt_d == LOCK_VAL) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                good_cnt_q <= '0;
              end else begin
                good_cnt_q <= good_cnt_d;
              end
            end else begin
              good_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (!good) begin
              state_q    <= ACQ;
              locked_q   <= 1'b0;
              err_q      <= 1'b1;
              good_cnt_q <= '0;
            end
          end
          default: begin
            state_q    <= IDLE;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (bus.clear),
    .q     (bus.err_cnt)
  );

  sat_counter #(.W(SW_W)) u_sw_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sw_inc),
    .clr   (bus.clear),
    .q     (bus.sw_cnt)
  );

  assign bus.locked = locked_q;
  assign bus.err    = err_q;
  assign bus.mode   = mode_q;

endmodule

// File: tb/tb_counter_monitor.sv
// -----------------------------------------------------------------------------
// tb_counter_monitor
// Drives two monitors (8-bit and 2-bit counters) with the same result stream
// and compares both against a behavioural model of the monitor rules.
// -----------------------------------------------------------------------------
module tb_counter_monitor;

  localparam int LOCK_CNT = 4;

  logic clk;
  logic rst_n;

  counter_monitor_if #(.ERR_W(8), .SW_W(8)) busA ();
  counter_monitor_if #(.ERR_W(2), .SW_W(2)) busB ();

  counter_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(8), .SW_W(8)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  counter_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(2), .SW_W(2)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integers describing what the monitor has seen.
  bit started;
  bit lockedM;
  int run;
  int prevCnt;
  int prevMode;
  int errTotal;
  int swTotal;
  bit expErr;

  // Generator state for the result stream.
  int genCnt;
  int genMode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int satMin(input int v, input int maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    started  = 0;
    lockedM  = 0;
    run      = 0;
    prevCnt  = 0;
    prevMode = 0;
    errTotal = 0;
    swTotal  = 0;
    expErr   = 0;
  endtask

  task automatic modelStep(input bit clr, input logic [3:0] res);
    int  c;
    int  m;
    bit  good;
    c    = res[3] ? (15 - int'(res)) : int'(res);
    m    = int'(res[3]);
    good = (c == ((prevCnt + 1) % 8));
    expErr = 0;
    if (clr) begin
      started  = 0;
      lockedM  = 0;
      run      = 0;
      errTotal = 0;
      swTotal  = 0;
    end else if (!started) begin
      started = 1;
      run     = 0;
    end else if (lockedM) begin
      if (!good) begin
        lockedM = 0;
        expErr  = 1;
        errTotal++;
        run     = 0;
      end else if (m != prevMode) begin
        swTotal++;
      end
    end else if (good) begin
      run++;
      if (run >= LOCK_CNT) begin
        lockedM = 1;
        run     = 0;
      end
    end else begin
      run = 0;
    end
    prevCnt  = c;
    prevMode = m;
  endtask

  // Every-cycle comparison of both DUTs against the model.
  task automatic checkOutput();
    checkVal("A.locked",  int'(busA.locked),  int'(lockedM));
    checkVal("A.err",     int'(busA.err),     int'(expErr));
    checkVal("A.mode",    int'(busA.mode),    prevMode);
    checkVal("A.err_cnt", int'(busA.err_cnt), satMin(errTotal, 255));
    checkVal("A.sw_cnt",  int'(busA.sw_cnt),  satMin(swTotal, 255));
    checkVal("B.locked",  int'(busB.locked),  int'(lockedM));
    checkVal("B.err",     int'(busB.err),     int'(expErr));
    checkVal("B.mode",    int'(busB.mode),    prevMode);
    checkVal("B.err_cnt", int'(busB.err_cnt), satMin(errTotal, 3));
    checkVal("B.sw_cnt",  int'(busB.sw_cnt),  satMin(swTotal, 3));
  endtask

  // Called at a negedge: drive inputs, let one edge sample them, check, and
  // return at the following negedge.
  task automatic applyStimulus(input bit clr, input logic [3:0] res);
    busA.clear  = clr;
    busA.result = res;
    busB.clear  = clr;
    busB.result = res;
    @(posedge clk);
    modelStep(clr, res);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic driveUp(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 4'((start + i) % 8));
    end
  endtask

  // Drop reset mid-cycle, confirm the outputs clear with no clock edge,
  // then release at a negedge.
  task automatic resetPulse();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    checkVal("rst.A.locked",  int'(busA.locked),  0);
    checkVal("rst.A.err_cnt", int'(busA.err_cnt), 0);
    checkVal("rst.A.sw_cnt",  int'(busA.sw_cnt),  0);
    checkVal("rst.A.mode",    int'(busA.mode),    0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int p;
    int bad;
    logic [3:0] res;
    bit clr;

    rst_n       = 1'b0;
    busA.clear  = 1'b0;
    busA.result = 4'd0;
    busB.clear  = 1'b0;
    busB.result = 4'd0;
    modelReset();
    #3;
    checkOutput();
    checkVal("init.A.locked", int'(busA.locked), 0);
    checkVal("init.A.err",    int'(busA.err),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire lock on 0..4.
    driveUp(0, 4);
    checkVal("lock.pre", int'(busA.locked), 0);
    applyStimulus(1'b0, 4'd4);
    checkVal("lock.at4", int'(busA.locked), 1);

    // Wrap 7->0, switch into the down range (0 -> 14 is cnt 0 -> 1), run
    // down through the 7 -> 0 wrap (8 -> 15).
    driveUp(5, 3);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd14);
    checkVal("sw.mode", int'(busA.mode), 1);
    checkVal("sw.cnt1", int'(busA.sw_cnt), 1);
    applyStimulus(1'b0, 4'd13);
    applyStimulus(1'b0, 4'd12);
    applyStimulus(1'b0, 4'd11);
    applyStimulus(1'b0, 4'd10);
    applyStimulus(1'b0, 4'd9);
    applyStimulus(1'b0, 4'd8);
    applyStimulus(1'b0, 4'd15);
    checkVal("down.locked",  int'(busA.locked),  1);
    checkVal("down.err_cnt", int'(busA.err_cnt), 0);
    checkVal("down.sw_cnt",  int'(busA.sw_cnt),  1);

    // Back to up range, then a 3 -> 5 violation.
    driveUp(1, 3);
    checkVal("up.sw_cnt", int'(busA.sw_cnt), 2);
    applyStimulus(1'b0, 4'd5);
    checkVal("viol.err",     int'(busA.err),     1);
    checkVal("viol.err_cnt", int'(busA.err_cnt), 1);
    checkVal("viol.locked",  int'(busA.locked),  0);
    applyStimulus(1'b0, 4'd6);
    checkVal("viol.errgone", int'(busA.err), 0);
    applyStimulus(1'b0, 4'd7);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd1);
    checkVal("relock", int'(busA.locked), 1);

    // Five violate/relock rounds to saturate the 2-bit error counter.
    p = 1;
    for (int k = 0; k < 5; k++) begin
      bad = (p + 2) % 8;
      applyStimulus(1'b0, 4'(bad));
      checkVal("sat.errpulse", int'(busB.err), 1);
      driveUp(bad + 1, 4);
      p = (bad + 4) % 8;
    end
    checkVal("sat.A.err_cnt", int'(busA.err_cnt), 6);
    checkVal("sat.B.err_cnt", int'(busB.err_cnt), 3);
    checkVal("sat.locked",    int'(busA.locked),  1);

    // Clear on the same edge as a bad value.
    applyStimulus(1'b1, 4'((p + 2) % 8));
    checkVal("clr.err",     int'(busA.err),     0);
    checkVal("clr.err_cnt", int'(busA.err_cnt), 0);
    checkVal("clr.sw_cnt",  int'(busA.sw_cnt),  0);
    checkVal("clr.locked",  int'(busA.locked),  0);
    driveUp(0, 4);
    checkVal("clr.acq", int'(busA.locked), 0);
    applyStimulus(1'b0, 4'd4);
    checkVal("clr.relock", int'(busA.locked), 1);

    // Asynchronous reset while locked, then relock.
    resetPulse();
    driveUp(0, 5);
    checkVal("rst.relock", int'(busA.locked), 1);

    // Randomised counter stream with mode flips, glitches and clears.
    genCnt  = 4;
    genMode = 0;
    for (int i = 0; i < 800; i++) begin
      genCnt = (genCnt + 1) % 8;
      if ($urandom_range(7, 0) == 0) genMode = 1 - genMode;
      res = genMode ? 4'(15 - genCnt) : 4'(genCnt);
      if ($urandom_range(15, 0) == 0) res = 4'($urandom_range(15, 0));
      clr = ($urandom_range(63, 0) == 0);
      applyStimulus(clr, res);
      if (i == 400) resetPulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
